operand_fetch: RTL and testbench
================================

# operand_fetch

Operand fetch stage that resolves memory-sourced ALU operands before the ALU input multiplexer selects its data. On a start pulse from the decoder it issues zero, one or two memory reads, depending on the addressing mode. It then presents the fetched word on `mem_data`, which the multiplexer consumes for memory-address and indirect sources. Register and immediate sources pass through with no memory traffic so decode sees a uniform done-handshake.

## Interface
Parameters:
- `WIDTH`, 8, data word width; also the width of `id_operand` and `mem_data`.
- `ADDR_WIDTH`, 8, memory address width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request from decode; sampled only in IDLE.
- `source`  in  `data_src_t`  addressing mode of the request.
- `id_operand`  in  `WIDTH`  address field from decode, used for MEM_ADDR and INDIRECT.
- `flush`  in  1  synchronous abort; returns the block to IDLE.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the operand is ready.
- `mem_data`  out  `WIDTH`  fetched operand register; holds its value until the next completed fetch.
- `mem_addr`  out  `ADDR_WIDTH`  memory read address (registered).
- `mem_rd`  out  1  memory read request (registered).
- `mem_ack`  in  1  read acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  `WIDTH`  memory read data.

## Operation
- States: IDLE, READ1, READ2, DONE.
- **Request capture:** in IDLE, `start=1` latches `source` and `id_operand`. `start` is ignored while `busy`.
- **SRC_REG / SRC_IMMEDIATE:** IDLE→DONE. No memory access; `mem_data` is unchanged.
- **SRC_MEM_ADDR:**
  - IDLE→READ1 with `mem_addr = id_operand[ADDR_WIDTH-1:0]` (zero-extended if `WIDTH < ADDR_WIDTH`) and `mem_rd = 1`.
  - On `mem_ack`: `mem_data ← mem_rdata`, then →DONE.
- **SRC_INDIRECT:**
  - READ1 as above.
  - On `mem_ack`: →READ2. `mem_addr ← mem_rdata` (truncated or zero-extended to `ADDR_WIDTH`), and `mem_rd` stays 1 with no gap.
  - On the second `mem_ack`: `mem_data ← mem_rdata`, then →DONE.
- **DONE:** `done = 1` for exactly one cycle, then →IDLE.
- **Memory handshake:**
  - `mem_rd` and `mem_addr` are held stable until `mem_ack` is sampled.
  - `mem_ack` while `mem_rd = 0` is ignored.
  - Wait states are unbounded; there is no timeout.
- **Unknown `source` encoding:** treated as SRC_REG (→DONE, no access).
- **`flush`:**
  - In any state: next state is IDLE, `mem_rd ← 0`, no `done` pulse, `mem_data` unchanged.
  - `flush` has priority over `mem_ack` in the same cycle.
  - `flush` together with `start` in IDLE: the request is dropped.
- **Reset values:** `busy=0`, `done=0`, `mem_rd=0`, `mem_addr=0`, `mem_data=0`, state IDLE. Asserting `rst_n` mid-fetch abandons the fetch immediately (asynchronous).

## Timing
- `start` is sampled at edge 0 (cycle 0).
- **REG/IMM:** `done` is high in cycle 1. Latency is 1 cycle.
- **MEM_ADDR:**
  - `mem_rd` is high from cycle 1.
  - If `mem_ack` is high in cycle k ≥ 1: `mem_data` updates and `done` is high in cycle k+1, and `mem_rd` is low in cycle k+1.
  - Minimum latency is 2 cycles.
- **INDIRECT:**
  - First ack in cycle k: the pointer address appears on `mem_addr` in cycle k+1 with `mem_rd` still high.
  - Second ack in cycle j > k: `done` is high in cycle j+1.
  - Minimum latency is 3 cycles.
- **Back-to-back requests:** the next `start` is accepted in the cycle after `done` (state IDLE). Peak throughput is one REG/IMM request per 2 cycles.
- **Output timing:** `busy` and `done` are decoded from the state register, so they are glitch-free and carry no combinational path from inputs.

## Structure
- `data_src_t` stays in the shared `enums.svh` package.
- Add `fetch_state_t` (IDLE, READ1, READ2, DONE) to the same package so the bench can probe state by name.
- No sub-module: a single FSM plus capture registers.

## Test plan
- **Reset values:** reset asserted mid-READ1, then released → all outputs 0 and state IDLE; a following `start` with SRC_REG gives `done` in cycle 1.
- **Immediate source:** SRC_IMMEDIATE with `id_operand=8'h5A` and `mem_data` previously `8'h11` → `done` in cycle 1, `mem_rd` never asserted, `mem_data` stays `8'h11`.
- **Direct memory read:** SRC_MEM_ADDR with `id_operand=8'h20`, ack after 3 wait cycles with `rdata=8'hC3` → `mem_addr=8'h20` held stable for 4 cycles, `mem_data=8'hC3`, and a single `done` pulse.
- **Indirect read:** SRC_INDIRECT with `id_operand=8'h10`; ack returns `8'h80` in cycle 1, then ack returns `8'h7E` in cycle 2 → `mem_addr` is `8'h10` then `8'h80` with `mem_rd` continuous, `mem_data=8'h7E`, `done` in cycle 3.
- **Flush with concurrent ack:** `flush` and `mem_ack` in the same cycle during READ2 → IDLE next cycle, no `done`, `mem_data` unchanged, `mem_rd` 0.
- **Start while busy:** `start` pulses during READ1 → ignored; exactly one `done` is produced, for the original request.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: ALU operand addressing modes and
// the fetch FSM state encoding (exposed so benches can probe state by name).
package operand_fetch_pkg;

  typedef enum logic [2:0] {
    SRC_REG       = 3'd0,
    SRC_IMMEDIATE = 3'd1,
    SRC_MEM_ADDR  = 3'd2,
    SRC_INDIRECT  = 3'd3
  } data_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ1 = 2'd1,
    READ2 = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves memory-sourced ALU operands with zero, one or
// two memory reads, presenting the result on mem_data with a done pulse.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  data_src_t             source,
  input  logic [WIDTH-1:0]      id_operand,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ack,
  input  logic [WIDTH-1:0]      mem_rdata
);

  fetch_state_t          state_reg, state_next;
  data_src_t             src_reg, src_next;
  logic [WIDTH-1:0]      data_reg, data_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  rd_reg, rd_next;

  // Truncate or zero-extend a data word to an address, independent of which is wider.
  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [WIDTH-1:0] w);
    logic [ADDR_WIDTH+WIDTH-1:0] ext;
    ext = {{ADDR_WIDTH{1'b0}}, w};
    return ext[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    rd_next    = rd_reg;
    if (flush) begin
      state_next = IDLE;
      rd_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_next = source;
            case (source)
              SRC_MEM_ADDR, SRC_INDIRECT: begin
                state_next = READ1;
                addr_next  = to_addr(id_operand);
                rd_next    = 1'b1;
              end
              default: state_next = DONE;
            endcase
          end
        end
        READ1: begin
          if (mem_ack) begin
            if (src_reg == SRC_INDIRECT) begin
              // Pointer word becomes the second address; mem_rd stays high.
              state_next = READ2;
              addr_next  = to_addr(mem_rdata);
            end else begin
              state_next = DONE;
              data_next  = mem_rdata;
              rd_next    = 1'b0;
            end
          end
        end
        READ2: begin
          if (mem_ack) begin
            state_next = DONE;
            data_next  = mem_rdata;
            rd_next    = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      src_reg   <= SRC_REG;
      data_reg  <= '0;
      addr_reg  <= '0;
      rd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
      rd_reg    <= rd_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign mem_data = data_reg;
  assign mem_addr = addr_reg;
  assign mem_rd   = rd_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table, randomized traffic
// against a transaction-level model, and hand sequences for flush/reset cases.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  data_src_t  source;
  logic [7:0] id_operand;
  logic       flush;
  logic       busy;
  logic       done;
  logic [7:0] mem_data;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_fetch #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .source(source),
    .id_operand(id_operand), .flush(flush), .busy(busy), .done(done),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    data_src_t  src;
    logic [7:0] op;
    int         w1;
    logic [7:0] d1;
    int         w2;
    logic [7:0] d2;
    int         exp_lat;
    int         exp_nreads;
    logic [7:0] exp_a1;
    logic [7:0] exp_a2;
    logic [7:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays the memory side, acking read n after ws[n] wait cycles.
  task automatic run_txn(input data_src_t src, input logic [7:0] op,
                         input int w1, input logic [7:0] d1,
                         input int w2, input logic [7:0] d2,
                         output int lat, output int nreads,
                         output logic [7:0] a1, output logic [7:0] a2,
                         output bit stable_ok, output bit rd_ok, output bit tail_ok);
    int wc;
    int cyc;
    int ws[2];
    logic [7:0] ds[2];
    logic [7:0] as[2];
    ws[0] = w1; ws[1] = w2;
    ds[0] = d1; ds[1] = d2;
    as[0] = 8'h00; as[1] = 8'h00;
    source = src; id_operand = op; start = 1'b1;
    cyc = 0; wc = 0; nreads = 0; lat = -1; stable_ok = 1'b1; rd_ok = 1'b1;
    forever begin
      tick();
      cyc++;
      start = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
      if (done) begin
        lat = cyc;
        if (mem_rd) rd_ok = 1'b0;
        break;
      end
      if (cyc > 100) break;
      if (mem_rd && nreads < 2) begin
        if (wc == 0) as[nreads] = mem_addr;
        else if (mem_addr !== as[nreads]) stable_ok = 1'b0;
        if (wc == ws[nreads]) begin
          mem_ack = 1'b1; mem_rdata = ds[nreads]; nreads++; wc = 0;
        end else wc++;
      end else rd_ok = 1'b0;
    end
    mem_ack = 1'b0;
    tick();
    tail_ok = !done && !busy && !mem_rd;
    a1 = as[0]; a2 = as[1];
  endtask

  task automatic check_txn(input string tag, input vec_t v);
    int lat, nr;
    logic [7:0] a1, a2;
    bit st, rk, tl;
    run_txn(v.src, v.op, v.w1, v.d1, v.w2, v.d2, lat, nr, a1, a2, st, rk, tl);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " nreads"}, nr, v.exp_nreads);
    chk({tag, " mem_data"}, mem_data, v.exp_data);
    chk({tag, " addr_stable"}, st, 1);
    chk({tag, " rd_continuous"}, rk, 1);
    chk({tag, " single_done"}, tl, 1);
    if (v.exp_nreads >= 1) chk({tag, " addr1"}, a1, v.exp_a1);
    if (v.exp_nreads >= 2) chk({tag, " addr2"}, a2, v.exp_a2);
    $display("txn %s src=%0d op=%02h lat=%0d reads=%0d data=%02h", tag, v.src, v.op, lat, nr, mem_data);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    logic [7:0] model_data;
    int ndone;
    logic [7:0] held;

    rst_n = 1'b0; start = 1'b0; source = SRC_REG; id_operand = 8'h00;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mem_rd", mem_rd, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_data", mem_data, 0);
    chk("reset state", dut.state_reg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    //          src             op     w1 d1     w2 d2     lat nr a1     a2     data
    tbl[0] = '{SRC_MEM_ADDR,  8'h44, 0, 8'h11, 0, 8'h00, 2,  1, 8'h44, 8'h00, 8'h11};
    tbl[1] = '{SRC_IMMEDIATE, 8'h5A, 0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 8'h00, 8'h11};
    tbl[2] = '{SRC_MEM_ADDR,  8'h20, 3, 8'hC3, 0, 8'h00, 5,  1, 8'h20, 8'h00, 8'hC3};
    tbl[3] = '{SRC_INDIRECT,  8'h10, 0, 8'h80, 0, 8'h7E, 3,  2, 8'h10, 8'h80, 8'h7E};
    tbl[4] = '{SRC_REG,       8'hFF, 0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 8'h00, 8'h7E};
    tbl[5] = '{data_src_t'(3'd6), 8'h33, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h7E};
    tbl[6] = '{SRC_INDIRECT,  8'hA5, 2, 8'h3C, 1, 8'hD2, 6,  2, 8'hA5, 8'h3C, 8'hD2};
    for (int i = 0; i < 7; i++) check_txn($sformatf("vec%0d", i), tbl[i]);

    // Randomized traffic against the transaction-level model.
    model_data = mem_data;
    for (int i = 0; i < 40; i++) begin
      v.src = data_src_t'(3'($urandom_range(0, 7)));
      v.op  = 8'($urandom);
      v.w1  = $urandom_range(0, 3);
      v.d1  = 8'($urandom);
      v.w2  = $urandom_range(0, 3);
      v.d2  = 8'($urandom);
      v.exp_a1 = v.op;
      v.exp_a2 = v.d1;
      if (v.src == SRC_MEM_ADDR) begin
        v.exp_nreads = 1; v.exp_lat = v.w1 + 2; model_data = v.d1;
      end else if (v.src == SRC_INDIRECT) begin
        v.exp_nreads = 2; v.exp_lat = v.w1 + v.w2 + 3; model_data = v.d2;
      end else begin
        v.exp_nreads = 0; v.exp_lat = 1;
      end
      v.exp_data = model_data;
      check_txn($sformatf("rnd%0d", i), v);
    end

    // Ack while idle must be ignored.
    held = mem_data;
    mem_ack = 1'b1; mem_rdata = ~held;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack mem_data", mem_data, held);
    chk("idle_ack busy", busy, 0);
    $display("txn idle_ack data=%02h", mem_data);

    // Flush together with start in IDLE drops the request.
    flush = 1'b1; start = 1'b1; source = SRC_REG;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_start busy", busy, 0);
    chk("flush_start done", done, 0);
    tick();
    chk("flush_start done2", done, 0);
    $display("txn flush_start busy=%0b", busy);

    // Start while busy is ignored; only the original request completes.
    source = SRC_MEM_ADDR; id_operand = 8'h40; start = 1'b1;
    tick();                                   // cycle 1
    source = SRC_REG; start = 1'b1;
    chk("busy_start state", dut.state_reg, READ1);
    ndone = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();                                 // cycle c
      start = 1'b0; mem_ack = 1'b0;
      if (done) begin
        ndone++;
        chk("busy_start done_cycle", c, 4);
      end
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 8'h66; end
    end
    chk("busy_start ndone", ndone, 1);
    chk("busy_start mem_data", mem_data, 8'h66);
    $display("txn busy_start dones=%0d data=%02h", ndone, mem_data);

    // Flush and ack together in READ2.
    source = SRC_INDIRECT; id_operand = 8'h30; start = 1'b1;
    tick();                                   // cycle 1: READ1
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h90;
    tick();                                   // cycle 2: READ2
    chk("flush_r2 state", dut.state_reg, READ2);
    chk("flush_r2 addr", mem_addr, 8'h90);
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h55;
    tick();                                   // cycle 3
    flush = 1'b0; mem_ack = 1'b0;
    chk("flush_r2 idle", dut.state_reg, IDLE);
    chk("flush_r2 done", done, 0);
    chk("flush_r2 mem_rd", mem_rd, 0);
    chk("flush_r2 mem_data", mem_data, 8'h66);
    tick();
    chk("flush_r2 done_late", done, 0);
    $display("txn flush_r2 data=%02h rd=%0b", mem_data, mem_rd);

    // Asynchronous reset mid-READ1, then a register request.
    source = SRC_MEM_ADDR; id_operand = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_mid state", dut.state_reg, READ1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid busy", busy, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid mem_rd", mem_rd, 0);
    chk("rst_mid mem_addr", mem_addr, 0);
    chk("rst_mid mem_data", mem_data, 0);
    chk("rst_mid state_idle", dut.state_reg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    source = SRC_REG; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_mid reg_done", done, 1);
    tick();
    chk("rst_mid reg_done_end", done, 0);
    $display("txn rst_mid done_ok state=%0d", dut.state_reg);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
